// File: rtl/game_ctrl.sv
// game_ctrl: frame-level sequencer for the obstacle-dodging game.
// It runs the IDLE -> COUNTDOWN -> RUN -> OVER cycle, enables and resets the
// obstacle animators, detects player/obstacle box overlap, and keeps the
// score, high score and difficulty level shown by the HUD.
//
// Ports:
//   i_clk, i_rst_n      base clock, asynchronous active-low reset
//   i_ani_stb           one-cycle animation strobe, once per frame
//   i_start             debounced start button (level; only the rising edge acts)
//   i_px1..i_py2        player box left/right/top/bottom, inclusive
//   i_ox1..i_oy2        obstacle boxes, obstacle k in bits [12k+11:12k]
//   o_animate           animate enable to all obstacle animators
//   o_obst_rst          one-cycle reset pulse to obstacle animators
//   o_state             0=IDLE 1=COUNTDOWN 2=RUN 3=OVER
//   o_collide           per-obstacle hit flags captured at game over
//   o_score, o_hiscore  current score, best score since reset
//   o_level             difficulty level
module game_ctrl #(
    parameter int N_OBST       = 2,
    parameter int COUNT_FRAMES = 120,
    parameter int SCORE_FRAMES = 30,
    parameter int LEVEL_PTS    = 10,
    parameter int MAX_LEVEL    = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ani_stb,
    input  logic                 i_start,
    input  logic [11:0]          i_px1,
    input  logic [11:0]          i_px2,
    input  logic [11:0]          i_py1,
    input  logic [11:0]          i_py2,
    input  logic [12*N_OBST-1:0] i_ox1,
    input  logic [12*N_OBST-1:0] i_ox2,
    input  logic [12*N_OBST-1:0] i_oy1,
    input  logic [12*N_OBST-1:0] i_oy2,
    output logic                 o_animate,
    output logic                 o_obst_rst,
    output logic [1:0]           o_state,
    output logic [N_OBST-1:0]    o_collide,
    output logic [15:0]          o_score,
    output logic [15:0]          o_hiscore,
    output logic [2:0]           o_level
);

    localparam int CNT_MAX = (COUNT_FRAMES > SCORE_FRAMES) ? COUNT_FRAMES : SCORE_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNT_FRAMES - 1);
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(SCORE_FRAMES - 1);
    localparam logic [2:0]       LVL_MAX = 3'(MAX_LEVEL);
    localparam logic [15:0]      LVL_PTS = 16'(LEVEL_PTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_RUN   = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_start_q;
    logic                r_animate;
    logic                r_obst_rst;
    logic [CNT_W-1:0]    r_cnt;
    logic [15:0]         r_score, r_hiscore;
    logic [2:0]          r_level;
    logic [N_OBST-1:0]   r_collide;

    logic [N_OBST-1:0]   w_hit;
    logic                w_start_rise;
    logic                w_start_act;
    logic                w_cd_done;
    logic                w_run_hit;
    logic                w_run_tick;
    logic                w_score_tick;
    logic [15:0]         w_score_inc;
    logic                w_lvl_up;

    // Inclusive box overlap; touching edges count as a hit.
    genvar k;
    generate
        for (k = 0; k < N_OBST; k++) begin : g_hit
            assign w_hit[k] = (i_px1 <= i_ox2[12*k +: 12]) & (i_ox1[12*k +: 12] <= i_px2) &
                              (i_py1 <= i_oy2[12*k +: 12]) & (i_oy1[12*k +: 12] <= i_py2);
        end
    endgenerate

    assign w_start_rise = i_start & ~r_start_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_rise) w_state_nxt = S_COUNT;
            S_COUNT: if (i_ani_stb && r_cnt == CD_LAST) w_state_nxt = S_RUN;
            S_RUN:   if (i_ani_stb && |w_hit) w_state_nxt = S_OVER;
            S_OVER:  if (w_start_rise) w_state_nxt = S_COUNT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode driving the datapath registers
    always_comb begin
        w_start_act  = w_start_rise & ((r_state == S_IDLE) | (r_state == S_OVER));
        w_cd_done    = (r_state == S_COUNT) & i_ani_stb & (r_cnt == CD_LAST);
        w_run_hit    = (r_state == S_RUN) & i_ani_stb & (|w_hit);
        w_run_tick   = (r_state == S_RUN) & i_ani_stb & ~(|w_hit);
        w_score_tick = w_run_tick & (r_cnt == SC_LAST);
        w_score_inc  = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
        // A saturated score no longer counts as an increment, so no level step.
        w_lvl_up     = w_score_tick & (r_score != 16'hFFFF) &
                       ((w_score_inc % LVL_PTS) == 16'd0) & (r_level < LVL_MAX);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_q  <= 1'b0;
            r_animate  <= 1'b0;
            r_obst_rst <= 1'b0;
            r_cnt      <= '0;
            r_score    <= '0;
            r_hiscore  <= '0;
            r_level    <= '0;
            r_collide  <= '0;
        end else begin
            r_start_q  <= i_start;
            r_obst_rst <= w_start_act;
            // Stays low on the RUN entry edge so enable follows the state by one
            // cycle, and drops on the same edge that leaves RUN.
            r_animate  <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
            if (w_start_act) begin
                r_cnt     <= '0;
                r_score   <= '0;
                r_level   <= '0;
                r_collide <= '0;
            end else if (r_state == S_COUNT) begin
                if (i_ani_stb) r_cnt <= w_cd_done ? '0 : r_cnt + CNT_W'(1);
            end else if (w_run_hit) begin
                // Collision wins over any score tick on the same strobe.
                r_collide <= w_hit;
                if (r_score > r_hiscore) r_hiscore <= r_score;
            end else if (w_run_tick) begin
                if (w_score_tick) begin
                    r_cnt   <= '0;
                    r_score <= w_score_inc;
                    if (w_lvl_up) r_level <= r_level + 3'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_state    = r_state;
    assign o_animate  = r_animate;
    assign o_obst_rst = r_obst_rst;
    assign o_collide  = r_collide;
    assign o_score    = r_score;
    assign o_hiscore  = r_hiscore;
    assign o_level    = r_level;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl with short frame counts. A reference model updates on
// every driven strobe and pushes the expected state into a queue; each test
// pops and compares after the DUT edge.
module tb_game_ctrl;

    localparam int NO = 2;
    localparam int CF = 4;
    localparam int SF = 2;
    localparam int LP = 3;
    localparam int ML = 7;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_ani_stb = 1'b0;
    logic              i_start = 1'b0;
    logic [11:0]       px1 = 12'd100, px2 = 12'd140, py1 = 12'd100, py2 = 12'd140;
    logic [11:0]       ox1 [NO];
    logic [11:0]       ox2 [NO];
    logic [11:0]       oy1 [NO];
    logic [11:0]       oy2 [NO];
    logic [12*NO-1:0]  i_ox1, i_ox2, i_oy1, i_oy2;
    logic              o_animate, o_obst_rst;
    logic [1:0]        o_state;
    logic [NO-1:0]     o_collide;
    logic [15:0]       o_score, o_hiscore;
    logic [2:0]        o_level;

    assign i_ox1 = {ox1[1], ox1[0]};
    assign i_ox2 = {ox2[1], ox2[0]};
    assign i_oy1 = {oy1[1], oy1[0]};
    assign i_oy2 = {oy2[1], oy2[0]};

    game_ctrl #(.N_OBST(NO), .COUNT_FRAMES(CF), .SCORE_FRAMES(SF),
                .LEVEL_PTS(LP), .MAX_LEVEL(ML)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb), .i_start(i_start),
        .i_px1(px1), .i_px2(px2), .i_py1(py1), .i_py2(py2),
        .i_ox1(i_ox1), .i_ox2(i_ox2), .i_oy1(i_oy1), .i_oy2(i_oy2),
        .o_animate(o_animate), .o_obst_rst(o_obst_rst), .o_state(o_state),
        .o_collide(o_collide), .o_score(o_score), .o_hiscore(o_hiscore), .o_level(o_level)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] hi;
        logic [2:0]  lv;
        logic [1:0]  col;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [1:0]  m_st;
    int          m_cnt;
    logic [15:0] m_sc, m_hi;
    logic [2:0]  m_lv;
    logic [1:0]  m_col;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_obst(input int k, input int x1, input int x2, input int y1, input int y2);
        ox1[k] = 12'(x1); ox2[k] = 12'(x2); oy1[k] = 12'(y1); oy2[k] = 12'(y2);
    endtask

    // Obstacle 0 sits one row below the player, obstacle 1 one column right.
    task automatic obst_clear();
        set_obst(0, 100, 140, 141, 160);
        set_obst(1, 141, 180, 120, 160);
    endtask

    function automatic logic [1:0] model_hit();
        logic [1:0] h;
        for (int k = 0; k < NO; k++)
            h[k] = (px1 <= ox2[k]) && (ox1[k] <= px2) && (py1 <= oy2[k]) && (oy1[k] <= py2);
        return h;
    endfunction

    task automatic model_reset();
        m_st = 2'd0; m_cnt = 0; m_sc = 16'd0; m_hi = 16'd0; m_lv = 3'd0; m_col = 2'b00;
    endtask

    task automatic model_start();
        m_st = 2'd1; m_cnt = 0; m_sc = 16'd0; m_lv = 3'd0; m_col = 2'b00;
    endtask

    // Drive one frame strobe (optionally together with a start edge) after a
    // gap of idle cycles; the model's expectation is queued.
    task automatic strobe(input bit with_start);
        logic [1:0] h;
        exp_t x;
        repeat (9) tick();
        h = model_hit();
        if (with_start && (m_st == 2'd0 || m_st == 2'd3)) begin
            model_start();
        end else begin
            case (m_st)
                2'd1: if (m_cnt == CF - 1) begin m_cnt = 0; m_st = 2'd2; end
                      else m_cnt++;
                2'd2: if (|h) begin
                          m_col = h;
                          if (m_sc > m_hi) m_hi = m_sc;
                          m_st = 2'd3;
                      end else if (m_cnt == SF - 1) begin
                          m_cnt = 0;
                          if (m_sc != 16'hFFFF) begin
                              m_sc = m_sc + 16'd1;
                              if ((m_sc % LP) == 0 && m_lv < 3'(ML)) m_lv = m_lv + 3'd1;
                          end
                      end else m_cnt++;
                default: ;
            endcase
        end
        x.st = m_st; x.sc = m_sc; x.hi = m_hi; x.lv = m_lv; x.col = m_col;
        sb.push_back(x);
        i_ani_stb = 1'b1;
        if (with_start) i_start = 1'b1;
        tick();
        i_ani_stb = 1'b0;
        i_start   = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        obst_clear();
        i_rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({o_state, o_animate, o_obst_rst, o_collide, o_score, o_hiscore, o_level} !== '0) begin
            n_fail++;
            $display("FAIL reset: state=%0d anim=%b orst=%b col=%b score=%0d hi=%0d lvl=%0d, want all 0",
                     o_state, o_animate, o_obst_rst, o_collide, o_score, o_hiscore, o_level);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start();
        int pulses = 0;
        i_start = 1'b1;
        model_start();
        for (int c = 0; c < 5; c++) begin
            tick();
            if (o_obst_rst) pulses++;
            if (c == 0) begin
                n_tests++;
                if (o_obst_rst !== 1'b1 || o_state !== 2'd1 || o_animate !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_pulse: orst=%b state=%0d anim=%b, want 1 1 0",
                             o_obst_rst, o_state, o_animate);
                end
            end
        end
        i_start = 1'b0;
        repeat (3) begin tick(); if (o_obst_rst) pulses++; end
        n_tests++;
        if (pulses != 1 || o_state !== 2'd1) begin
            n_fail++;
            $display("FAIL start_once: pulses=%0d state=%0d, want 1 pulse state 1", pulses, o_state);
        end
    endtask

    task automatic test_countdown();
        for (int s = 0; s < CF; s++) begin
            strobe(1'b0);
            e = sb.pop_front();
            n_tests++;
            if (o_state !== e.st || o_animate !== 1'b0) begin
                n_fail++;
                $display("FAIL countdown[%0d]: state=%0d anim=%b, want %0d 0", s, o_state, o_animate, e.st);
            end
            if (s == 1) begin
                // A fresh start edge during countdown must be ignored.
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
                n_tests++;
                if (o_state !== 2'd1 || o_obst_rst !== 1'b0) begin
                    n_fail++;
                    $display("FAIL countdown_start_ignored: state=%0d orst=%b, want 1 0", o_state, o_obst_rst);
                end
            end
        end
        n_tests++;
        if (o_state !== 2'd2) begin
            n_fail++;
            $display("FAIL countdown_len: state=%0d, want 2", o_state);
        end
        tick();
        n_tests++;
        if (o_animate !== 1'b1) begin
            n_fail++;
            $display("FAIL animate_delay: anim=%b, want 1", o_animate);
        end
    endtask

    task automatic test_scoring();
        for (int s = 0; s < 12; s++) begin
            strobe(1'b0);
            e = sb.pop_front();
            n_tests++;
            if (o_state !== e.st || o_score !== e.sc || o_level !== e.lv || o_animate !== 1'b1) begin
                n_fail++;
                $display("FAIL score[%0d]: state=%0d score=%0d lvl=%0d anim=%b, want %0d %0d %0d 1",
                         s, o_state, o_score, o_level, o_animate, e.st, e.sc, e.lv);
            end
        end
        n_tests++;
        if (o_score !== 16'd6 || o_level !== 3'd2) begin
            n_fail++;
            $display("FAIL score_total: score=%0d lvl=%0d, want 6 2", o_score, o_level);
        end
    endtask

    task automatic test_collision();
        strobe(1'b0);
        e = sb.pop_front();
        n_tests++;
        if (o_state !== e.st || o_score !== e.sc) begin
            n_fail++;
            $display("FAIL pre_collide: state=%0d score=%0d, want %0d %0d", o_state, o_score, e.st, e.sc);
        end
        set_obst(1, 140, 180, 120, 160);
        strobe(1'b0);
        e = sb.pop_front();
        n_tests++;
        if (o_state !== e.st || o_collide !== e.col || o_score !== e.sc ||
            o_hiscore !== e.hi || o_animate !== 1'b0) begin
            n_fail++;
            $display("FAIL collide: state=%0d col=%b score=%0d hi=%0d anim=%b, want %0d %b %0d %0d 0",
                     o_state, o_collide, o_score, o_hiscore, o_animate, e.st, e.col, e.sc, e.hi);
        end
        repeat (5) tick();
        n_tests++;
        if (o_state !== 2'd3 || o_collide !== 2'b10 || o_score !== 16'd6 || o_hiscore !== 16'd6) begin
            n_fail++;
            $display("FAIL over_hold: state=%0d col=%b score=%0d hi=%0d, want 3 10 6 6",
                     o_state, o_collide, o_score, o_hiscore);
        end
    endtask

    task automatic test_restart();
        obst_clear();
        // Start edge and strobe together: start wins, counter stays at 0.
        strobe(1'b1);
        e = sb.pop_front();
        n_tests++;
        if (o_state !== e.st || o_obst_rst !== 1'b1 || o_score !== e.sc ||
            o_collide !== e.col || o_hiscore !== e.hi) begin
            n_fail++;
            $display("FAIL restart: state=%0d orst=%b score=%0d col=%b hi=%0d, want %0d 1 %0d %b %0d",
                     o_state, o_obst_rst, o_score, o_collide, o_hiscore, e.st, e.sc, e.col, e.hi);
        end
        for (int s = 0; s < CF + 4; s++) begin
            strobe(1'b0);
            e = sb.pop_front();
            n_tests++;
            if (o_state !== e.st || o_score !== e.sc || o_obst_rst !== 1'b0) begin
                n_fail++;
                $display("FAIL restart_run[%0d]: state=%0d score=%0d orst=%b, want %0d %0d 0",
                         s, o_state, o_score, o_obst_rst, e.st, e.sc);
            end
        end
        set_obst(1, 140, 180, 120, 160);
        strobe(1'b0);
        e = sb.pop_front();
        n_tests++;
        if (o_state !== e.st || o_hiscore !== e.hi || o_score !== e.sc || o_collide !== e.col) begin
            n_fail++;
            $display("FAIL restart_collide: state=%0d hi=%0d score=%0d col=%b, want %0d %0d %0d %b",
                     o_state, o_hiscore, o_score, o_collide, e.st, e.hi, e.sc, e.col);
        end
        n_tests++;
        if (o_hiscore !== 16'd6 || o_score !== 16'd2) begin
            n_fail++;
            $display("FAIL hiscore_kept: hi=%0d score=%0d, want 6 2", o_hiscore, o_score);
        end
    endtask

    task automatic test_async_reset();
        obst_clear();
        tick();
        i_start = 1'b1;
        model_start();
        tick();
        i_start = 1'b0;
        for (int s = 0; s < CF + 2; s++) begin
            strobe(1'b0);
            e = sb.pop_front();
        end
        n_tests++;
        if (o_state !== 2'd2 || o_score !== e.sc || o_animate !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_run: state=%0d score=%0d anim=%b, want 2 %0d 1", o_state, o_score, o_animate, e.sc);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({o_state, o_animate, o_obst_rst, o_collide, o_score, o_hiscore, o_level} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d anim=%b orst=%b col=%b score=%0d hi=%0d lvl=%0d, want all 0",
                     o_state, o_animate, o_obst_rst, o_collide, o_score, o_hiscore, o_level);
        end
        tick();
        i_rst_n = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (o_state !== 2'd0 || o_hiscore !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: state=%0d hi=%0d, want 0 0", o_state, o_hiscore);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start();
        test_countdown();
        test_scoring();
        test_collision();
        test_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
